cmult_pipe: RTL
===============

Name: cmult_pipe

Overview:
- Parametrised, pipelined signed complex multiplier with valid/ready handshake: q = a*b, or q = a*conj(b) per sample.
- Uses the 3-multiplier form with pre-adders. Scales the result by a right shift and saturates it to OW bits.
- Sits between the NCO/mixer and the filter chain.
- Successor of the fixed 16-bit, handshake-free complex multiplier.

Parameters:
- W, 16, input component width (signed two's complement), 4..24
- OW, 32, output component width, 4..2W+1
- SHIFT, 0, arithmetic right shift applied to the full-precision result before saturation, 0..2W
- TAG_W, 4, width of the sideband tag carried alongside each sample

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- conj  in  1  1: multiply by conj(b); sampled with the data
- ar, ai  in  W each  a real/imag, signed
- br, bi  in  W each  b real/imag, signed
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- qr, qi  out  OW each  result real/imag, signed
- out_tag  out  TAG_W  tag aligned with qr/qi
- sat  out  1  this output sample was saturated (either component)
- sat_sticky  out  1  any saturation since reset or the last clr
- clr  in  1  synchronous clear of sat_sticky

Behaviour:
- Global pipeline enable: en = ~out_valid | out_ready. in_ready = en (combinational). A transfer occurs when in_valid & in_ready.
- Three register stages, all advancing only when en = 1. Latency is 3 cycles from input transfer to out_valid. Full throughput is 1 sample per clock.
- While en = 0, every stage holds, including bubbles. Output data and tag stay stable while out_valid & ~out_ready.
- Stage 1 (pre-add, W+1 bits, sign-extended):
  - bie = conj ? -bi : bi, in W+1 bits, so -(-2^(W-1)) is exact.
  - s1 = br + bie; s2 = ar + ai; s3 = ai - ar.
  - ar, br, bie are registered alongside.
- Stage 2 (multiply, full precision, 2W+1 bits): m1 = ar*s1; m2 = bie*s2; m3 = br*s3.
- Stage 3 (post-add, 2W+2 bits):
  - re = m1 - m2 (= ar*br - ai*bie); im = m1 + m3 (= ar*bie + ai*br).
  - Then arithmetic shift right by SHIFT, truncation toward -inf by default.
  - Then saturation to [-2^(OW-1), 2^(OW-1)-1]. The result is registered into qr/qi.
- sat = 1 for an output sample if re or im clipped. It is registered with the data and valid only with out_valid.
- sat_sticky sets on any sample leaving stage 3 with sat = 1. clr clears it. If clr and a new saturation occur in the same cycle, the set wins.
- Valid bits shift per stage with the data. out_valid is the stage-3 valid bit.
- Reset (rst_n = 0 at a clock edge):
  - All valid bits, qr, qi, out_tag, sat and sat_sticky go to 0.
  - In-flight samples are discarded. in_ready = 1 in the first cycle after reset is released.
  - Reset overrides en and clr.
- conj and tag travel with their own sample. Mixed conj values in consecutive samples are legal.

Optional Feature:
- Macro CMULT_ROUND_EN.
- Defined: when SHIFT > 0, add 2^(SHIFT-1) before the shift (round half up), then saturate. Overflow from rounding is caught by saturation. Latency is unchanged. Rounding is applied in stage 3.
- Not defined: plain truncation. For SHIFT = 0 the result is identical with or without the macro.

Test Plan:
1. Defaults, a=(3,4), b=(5,-2), conj=0 -> q=(23,14) 3 cycles later, sat=0. Same inputs with conj=1 -> q=(7,26).
2. Defaults, a=b=(-32768,-32768), conj=0 -> re=0, im=2^31 -> qr=0, qi=2147483647, sat=1, sat_sticky=1. Then clr=1 -> sat_sticky=0.
3. Back-to-back stream of 8 samples with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order, each result matching the reference model.
4. Backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready=0 and qr/qi/out_tag held stable. On release, no sample is lost or duplicated.
5. W=8, OW=8, SHIFT=7, a=(127,0), b=(127,0) -> 16129>>7 = 126. With CMULT_ROUND_EN -> 126 (16129+64=16193, >>7 = 126). a=b=(-128,0) -> 16384>>7 = 128 -> saturates to 127, sat=1.
6. Assert rst_n=0 mid-stream with 3 samples in flight -> out_valid=0 and outputs 0 on the next edge, nothing emitted after reset. A fresh sample afterwards gives a correct result at latency 3.

Source files
------------

// File: rtl/cmult_pipe.sv
// cmult_pipe: 3-stage signed complex multiplier (q = a*b or a*conj(b)) using the 3-multiplier
// form, arithmetic right shift by SHIFT, then saturation to OW bits. Define CMULT_ROUND_EN for round-half-up.
module cmult_pipe #(
  parameter int W     = 16,
  parameter int OW    = 32,
  parameter int SHIFT = 0,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             conj,
  input  logic [W-1:0]     ar,
  input  logic [W-1:0]     ai,
  input  logic [W-1:0]     br,
  input  logic [W-1:0]     bi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    qr,
  output logic [OW-1:0]    qi,
  output logic [TAG_W-1:0] out_tag,
  output logic             sat,
  output logic             sat_sticky,
  input  logic             clr
);
  localparam int P1 = W + 1;
  localparam int PM = 2*W + 2;
  localparam int PE = 2*W + 3;
  localparam logic signed [PE-1:0] ONE  = PE'(1);
  localparam logic signed [PE-1:0] MAXV = (ONE <<< (OW-1)) - ONE;
  localparam logic signed [PE-1:0] MINV = -(ONE <<< (OW-1));
`ifdef CMULT_ROUND_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [PE-1:0] RND = (SHIFT > 0) ? (ONE <<< RSH) : '0;
`endif

  logic en;
  logic v1, v2;
  logic [TAG_W-1:0] tag1, tag2;
  logic signed [P1-1:0] ar1, br1, bie1, s1, s2, s3;
  logic signed [PM-1:0] m1, m2, m3;

  logic signed [P1-1:0] ar_x, ai_x, br_x, bie_x;
  logic signed [PE-1:0] re_f, im_f, re_s, im_s;
  logic [OW-1:0] qr_n, qi_n;
  logic re_clip, im_clip;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // One extra bit so negating the most negative bi stays exact.
  always_comb begin
    ar_x  = P1'($signed(ar));
    ai_x  = P1'($signed(ai));
    br_x  = P1'($signed(br));
    bie_x = conj ? -P1'($signed(bi)) : P1'($signed(bi));
  end

  always_comb begin
    re_f = PE'(m1) - PE'(m2);
    im_f = PE'(m1) + PE'(m3);
`ifdef CMULT_ROUND_EN
    re_f = re_f + RND;
    im_f = im_f + RND;
`endif
    re_s    = re_f >>> SHIFT;
    im_s    = im_f >>> SHIFT;
    re_clip = (re_s > MAXV) || (re_s < MINV);
    im_clip = (im_s > MAXV) || (im_s < MINV);
    if (re_s > MAXV)      qr_n = MAXV[OW-1:0];
    else if (re_s < MINV) qr_n = MINV[OW-1:0];
    else                  qr_n = re_s[OW-1:0];
    if (im_s > MAXV)      qi_n = MAXV[OW-1:0];
    else if (im_s < MINV) qi_n = MINV[OW-1:0];
    else                  qi_n = im_s[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag1 <= in_tag;
      ar1  <= ar_x;
      br1  <= br_x;
      bie1 <= bie_x;
      s1   <= br_x + bie_x;
      s2   <= ar_x + ai_x;
      s3   <= ai_x - ar_x;
      tag2 <= tag1;
      m1   <= PM'(ar1) * PM'(s1);
      m2   <= PM'(bie1) * PM'(s2);
      m3   <= PM'(br1) * PM'(s3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      qr         <= '0;
      qi         <= '0;
      out_tag    <= '0;
      sat        <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      if (en) begin
        v1        <= in_valid;
        v2        <= v1;
        out_valid <= v2;
        qr        <= qr_n;
        qi        <= qi_n;
        out_tag   <= tag2;
        sat       <= v2 & (re_clip | im_clip);
      end
      if (en && v2 && (re_clip || im_clip)) sat_sticky <= 1'b1;
      else if (clr)                         sat_sticky <= 1'b0;
    end
  end
endmodule
